// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Two-requester UART transmitter with round-robin arbitration.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   rst       asynchronous active-high reset
//   baud_en   one-cycle bit-period strobe from the baud-rate generator
//   req0/1    transmit requests from requester 0 / requester 1
//   data0/1   byte to send, held stable while the matching req is high
//   gnt0/1    registered one-cycle pulse: the byte has been captured
//   tx        registered serial line, idle high
//   busy      high whenever the FSM is not in IDLE
//   last_src  index of the most recently granted requester
//
// Parameter:
//   STOP_BITS number of stop-bit periods per frame (1 or 2)
// ---------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_en,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       tx,
   output logic       busy,
   output logic       last_src
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SYNC  = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] DATA  = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;

   logic [2:0] state;
   logic [7:0] shift_reg;
   logic [2:0] bit_cnt;
   logic [1:0] stop_cnt;
   logic       grant_sel;

   // Arbitration: a lone request wins outright; under contention the
   // requester that did not win last time is chosen.
   always_comb begin
      grant_sel = 1'b0;
      if (req0 && req1) begin
         grant_sel = ~last_src;
      end else begin
         grant_sel = req1;
      end
   end

   assign busy = (state != IDLE);

   // Main sequencer. The SYNC state exists so that a baud_en landing on the
   // grant edge is ignored: the start bit always begins on a fresh baud_en
   // and therefore lasts a full bit interval. Every tx change is made only
   // on a baud_en, so each level persists exactly one baud interval.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         last_src  <= 1'b1;
         shift_reg <= 8'h00;
         bit_cnt   <= 3'd0;
         stop_cnt  <= 2'd0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  shift_reg <= grant_sel ? data1 : data0;
                  last_src  <= grant_sel;
                  gnt0      <= ~grant_sel;
                  gnt1      <= grant_sel;
                  state     <= SYNC;
               end
            end
            SYNC: begin
               if (baud_en) begin
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud_en) begin
                  tx        <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_cnt   <= 3'd0;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (baud_en) begin
                  if (bit_cnt == 3'd7) begin
                     tx       <= 1'b1;
                     stop_cnt <= 2'(STOP_BITS);
                     state    <= STOP;
                  end else begin
                     tx        <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     bit_cnt   <= bit_cnt + 3'd1;
                  end
               end
            end
            STOP: begin
               if (baud_en) begin
                  stop_cnt <= stop_cnt - 2'd1;
                  if (stop_cnt == 2'd1) begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, meaning number of stop-bit periods per frame (legal values 1 or 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port baud_en  input  1  one-cycle bit-period strobe from the baud-rate generator.
REQ-005 SHALL have ports req0, req1  input  1 each  transmit requests from requester 0 and requester 1.
REQ-006 SHALL have ports data0, data1  input  8 each  byte to send, held stable by its requester while its req is high.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  registered one-cycle grant pulse: the byte has been captured.
REQ-008 SHALL have port tx  output  1  registered serial line; idle high.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port last_src  output  1  index of the most recently granted requester.

Function
REQ-011 SHALL implement the FSM states IDLE, SYNC, START, DATA and STOP.
REQ-012 SHALL sample req0/req1 only in IDLE; requests in all other states are ignored and not queued.
REQ-013 In IDLE with exactly one req high, SHALL grant that requester.
REQ-014 In IDLE with both req high, SHALL grant the requester not equal to last_src (round-robin).
REQ-015 At the grant edge SHALL load the 8-bit shift register from the selected data, update last_src, pulse the matching gnt for exactly one cycle and enter SYNC.
REQ-016 A baud_en high on the same cycle as a grant SHALL be ignored; SYNC waits for the next baud_en.
REQ-017 In SYNC on baud_en, SHALL drive tx=0 and enter START.
REQ-018 In START on baud_en, SHALL drive tx=bit0 (LSB first), clear the 3-bit bit counter and enter DATA.
REQ-019 In DATA on each baud_en, SHALL drive the next bit and increment the bit counter; on the baud_en after bit7 has been driven, SHALL drive tx=1, load the stop counter with STOP_BITS and enter STOP.
REQ-020 In STOP on each baud_en, SHALL decrement the stop counter; when it reaches zero, SHALL enter IDLE with tx remaining 1.
REQ-021 Every tx level SHALL persist for exactly one baud_en-to-baud_en interval; a frame SHALL be 1+8+STOP_BITS intervals.
REQ-022 Without baud_en, the FSM SHALL hold its state and tx indefinitely.
REQ-023 After returning to IDLE, a pending request SHALL be granted on the next clock; tx SHALL stay high through the following SYNC.
REQ-024 gnt0 and gnt1 SHALL never be high together, and at most one grant SHALL occur per frame.
REQ-025 busy SHALL rise on the cycle after the grant edge and fall on the cycle after the final stop-bit baud_en.

Reset
REQ-026 While rst is high, SHALL force state=IDLE, tx=1, gnt0=gnt1=0, busy=0, last_src=1, and zero the counters and shift register.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); the byte SHALL NOT be resumed.
REQ-028 After reset release, with both req high, the first grant SHALL go to req0.

Verification
REQ-029 Single request: baud_en every 4 clocks, req0=1, data0=8'hA5 -> one gnt0 pulse, then tx sequence 0,1,0,1,0,0,1,0,1,1, with each level lasting 4 clocks; busy then falls.
REQ-030 Contention: req0=req1=1 continuously, data0=8'h55, data1=8'hAA -> grants alternate gnt0, gnt1, gnt0, ..., with no missed or double grants.
REQ-031 STOP_BITS=2, data1=8'h00 -> tx low for 9 intervals, then high for 2 intervals before busy falls.
REQ-032 Baud_en coincident with the grant edge -> tx stays high until the next baud_en; the start bit lasts one full interval.
REQ-033 rst pulsed during DATA bit3 -> tx=1 and busy=0 in the same cycle; after release with req1=1 only, gnt1 pulses and a full new frame follows.
REQ-034 baud_en held low for 100 clocks mid-frame -> tx and state remain frozen, and the frame completes correctly once baud_en resumes.
